mux41_rr_arbiter: RTL and testbench
===================================

Name: mux41_rr_arbiter

Overview:
Round-robin arbiter that shares the single output channel of the mux41 4:1 select datapath among four requesters. It drives mux41 sel[1:0] so that each requester owns the channel for a multi-beat transfer. A transfer ends on the requester's last beat, or when the requester abandons it. Sits directly in front of mux41: requester data goes to mux41 d0..d3, and the arbiter sequences sel and the output valid/ready handshake.

Parameters:
MAX_HOLD, 16, max cycles one owner may hold the grant (used only when GRANT_TIMEOUT_EN is defined); legal range 2..256
HOLD_W, $clog2(MAX_HOLD), width of internal hold counter (derived, do not override)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
req  input  4  per-requester request; bit i held high while requester i has beats to send
last  input  4  per-requester last-beat flag; sampled only for current owner on an accepted beat
out_ready  input  1  downstream accepts a beat this cycle
gnt  output  4  one-hot grant, registered; all-zero when idle
sel  output  2  mux41 select, registered; equals index of gnt bit while granted
out_valid  output  1  beat on mux41 y is valid
busy  output  1  high while in GRANT state
timeout  output  1  one-cycle pulse on forced release; tied 0 without GRANT_TIMEOUT_EN

Behaviour:
- Reset (rst=1 at clk edge): state IDLE, gnt=4'b0000, sel=2'b00, out_valid=0, busy=0, timeout=0, priority pointer ptr=2'b00, hold counter=0. Reset mid-transfer drops the transfer; no beat completes in the reset cycle.
- Arbitration function: first set bit of req scanning ptr, ptr+1, ptr+2, ptr+3, indices mod 4 with 2-bit wrap (3+1 -> 0).
- IDLE: if req != 0, the winner is registered into gnt/sel and the state goes to GRANT on the next edge. Latency is 1 cycle from req to gnt. In IDLE, sel holds its last value; gnt=0.
- GRANT: out_valid = req[sel] combinationally from the registered sel; busy=1. A beat is accepted when out_valid & out_ready.
- Release conditions, evaluated each GRANT cycle:
  (a) accepted beat with last[sel]=1;
  (b) req[sel]=0, abandon with no beat;
  (c) timeout, optional feature only.
- On release: ptr <= sel+1 (mod 4). The arbitration function is then evaluated with the updated ptr over req, excluding the releasing index for that decision.
  - If there is a winner, it is granted on the next edge and the state stays GRANT: back-to-back handoff, no dead cycle.
  - If there is no winner, go to IDLE with gnt=0.
- Requests from non-owners during GRANT are ignored until release. The owner cannot be preempted.
- last is ignored when out_ready=0 or for non-owner bits.
- gnt is always one-hot or zero. sel never changes while a grant is held without a release.

Optional Feature:
GRANT_TIMEOUT_EN
- Defined: the hold counter clears on each new grant and increments every GRANT cycle. When it reaches MAX_HOLD-1 with no other release, a forced release occurs at the end of that cycle. A beat accepted in that cycle still completes. timeout pulses high for that one cycle, and the next owner is chosen as in normal release.
- Not defined: no counter is instantiated, an owner holds until last or abandon, and timeout is constant 0.

Test Plan:
1. Reset with req=4'b1111 held -> gnt=0, sel=0, out_valid=0 during reset; the first edge after deassert gives gnt=4'b0001, sel=0.
2. req=4'b1111 and out_ready=1, each requester sends 2 beats (last on the 2nd) -> grant order 0,1,2,3,0, each held exactly 2 cycles, handoff with no idle cycle, sel tracks 0,1,2,3.
3. Owner 2 with out_ready=0 for 5 cycles, last[2]=1 asserted -> gnt stays 4'b0100, no release; release occurs the cycle after out_ready goes 1.
4. Owner 1 drops req[1] without last, req=4'b1001 -> release, next gnt=4'b1000 (ptr=2 scans 2,3), out_valid=0 in the abandon cycle.
5. Only req[3] active and released, then req=4'b0001 -> IDLE for 1 cycle (gnt=0, busy=0), then gnt=4'b0001 (wrap 3->0).
6. GRANT_TIMEOUT_EN, MAX_HOLD=4, owner 0 never asserts last, req=4'b0011 -> timeout pulses in the 4th grant cycle, next gnt=4'b0010; without the macro, owner 0 holds indefinitely and timeout stays 0.

Source files
------------

// File: rtl/mux41_rr_arbiter.sv
// Round-robin arbiter driving the mux41 select for four requesters.
// Each owner holds the channel for a multi-beat transfer. The transfer ends on an
// accepted last beat, or when the owner drops its request. On release the grant
// moves straight to the next requester, so there is no dead cycle.
// Optional macro GRANT_TIMEOUT_EN adds a hold counter that forces a release once
// an owner has held the grant for MAX_HOLD cycles.
module mux41_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned HOLD_W   = $clog2(MAX_HOLD)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] last,
  input  logic       out_ready,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       out_valid,
  output logic       busy,
  output logic       timeout
);

  localparam logic st_idle  = 1'b0;
  localparam logic st_grant = 1'b1;

  logic       state;
  logic [1:0] ptr;
  logic       accept;
  logic       rel_norm;
  logic       rel;
  logic       tmo;
  logic [3:0] cand;
  logic [1:0] base;
  logic       win_found;
  logic [1:0] win_idx;

  // Handshake and normal release: last beat accepted, or the owner abandons.
  always_comb begin
    busy      = (state == st_grant);
    out_valid = busy & req[sel];
    accept    = out_valid & out_ready;
    rel_norm  = busy & ((accept & last[sel]) | ~req[sel]);
    rel       = rel_norm | tmo;
  end

  // Scan from the pointer. During a grant, the candidate set is the handoff set:
  // the scan starts after the owner, and the owner is excluded.
  always_comb begin
    logic [1:0] idx;
    idx       = 2'd0;
    base      = busy ? sel + 2'd1 : ptr;
    cand      = busy ? (req & ~(4'b0001 << sel)) : req;
    win_found = 1'b0;
    win_idx   = base;
    // Descending offsets, so the lowest offset from base is the last to overwrite.
    for (int i = 3; i >= 0; i--) begin
      idx = base + 2'(i);
      if (cand[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

`ifdef GRANT_TIMEOUT_EN
  logic [HOLD_W-1:0] hold_cnt;

  // A forced release only fires when no normal release happens in the same cycle.
  assign tmo = busy & ~rel_norm & (hold_cnt == HOLD_W'(MAX_HOLD - 1));

  // Hold counter clears on every new grant and counts each held cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if (!busy || rel) begin
      hold_cnt <= '0;
    end else begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{HOLD_W[0], MAX_HOLD[0]};
  assign tmo        = 1'b0;
`endif

  assign timeout = tmo;

  // Grant state: idle pickup, back-to-back handoff on release, or drop to idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= st_idle;
      gnt   <= 4'b0000;
      sel   <= 2'b00;
      ptr   <= 2'b00;
    end else if (!busy) begin
      if (win_found) begin
        state <= st_grant;
        gnt   <= 4'b0001 << win_idx;
        sel   <= win_idx;
      end
    end else if (rel) begin
      ptr <= sel + 2'd1;
      if (win_found) begin
        gnt <= 4'b0001 << win_idx;
        sel <= win_idx;
      end else begin
        state <= st_idle;
        gnt   <= 4'b0000;
      end
    end
  end

endmodule

// File: tb/tb_mux41_rr_arbiter.sv
// Directed bench for mux41_rr_arbiter with a cycle-level behavioural model.
// Build with or without GRANT_TIMEOUT_EN. MAX_HOLD is 4 here.
module tb_mux41_rr_arbiter;

  localparam int unsigned MH = 4;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] last;
  logic       out_ready;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       out_valid;
  logic       busy;
  logic       timeout;

  int tests = 0;
  int fails = 0;

  mux41_rr_arbiter #(.MAX_HOLD(MH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .last      (last),
    .out_ready (out_ready),
    .gnt       (gnt),
    .sel       (sel),
    .out_valid (out_valid),
    .busy      (busy),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model state: owner index (-1 when idle), last select, priority pointer, held cycles.
  int own = -1;
  int msel = 0;
  int mptr = 0;
  int mhold = 0;
  bit mvalid = 0;

  function automatic int pick(input logic [3:0] r, input int p);
    for (int off = 0; off < 4; off++) begin
      if (r[(p + off) % 4]) return (p + off) % 4;
    end
    return -1;
  endfunction

  function automatic bit m_tmo();
`ifdef GRANT_TIMEOUT_EN
    if (own < 0) return 1'b0;
    if (!req[own]) return 1'b0;
    if (out_ready && last[own]) return 1'b0;
    return mhold == int'(MH) - 1;
`else
    return 1'b0;
`endif
  endfunction

  // Advance the model on each edge.
  always @(posedge clk) begin
    int w;
    bit r;
    if (rst) begin
      own = -1; msel = 0; mptr = 0; mhold = 0; mvalid = 1;
    end else if (mvalid) begin
      if (own < 0) begin
        w = pick(req, mptr);
        if (w >= 0) begin own = w; msel = w; mhold = 0; end
      end else begin
        r = (req[own] && out_ready && last[own]) || !req[own] || m_tmo();
        if (r) begin
          mptr = (own + 1) % 4;
          w = pick(req & ~(4'b0001 << own), mptr);
          if (w >= 0) begin own = w; msel = w; mhold = 0; end
          else own = -1;
        end else begin
          mhold++;
        end
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (mvalid) begin
      chk($sformatf("gnt@%0t", $time), 32'(gnt), (own < 0) ? 32'h0 : (32'h1 << own));
      chk($sformatf("sel@%0t", $time), 32'(sel), 32'(msel));
      chk($sformatf("out_valid@%0t", $time), 32'(out_valid),
          32'((own >= 0) && req[(own < 0) ? 0 : own]));
      chk($sformatf("busy@%0t", $time), 32'(busy), 32'(own >= 0));
      chk($sformatf("timeout@%0t", $time), 32'(timeout), 32'(m_tmo()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1; req = 4'b1111; last = 4'b0000; out_ready = 1'b0;

    // Reset with all requests high.
    tick(); tick(); settle();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_sel", 32'(sel), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    tick();

    // Two-beat transfers rotate 0,1,2,3,0.
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      last = 4'b0000; settle();
      chk($sformatf("rr_gnt_k%0d_b1", k), 32'(gnt), 32'h1 << (k % 4));
      chk($sformatf("rr_sel_k%0d", k), 32'(sel), 32'(k % 4));
      chk($sformatf("rr_valid_k%0d", k), 32'(out_valid), 32'h1);
      tick();
      last = 4'b1111; settle();
      chk($sformatf("rr_gnt_k%0d_b2", k), 32'(gnt), 32'h1 << (k % 4));
      tick();
    end

    // Owner 1 abandons; the scan from 2 finds 3.
    last = 4'b0000; req = 4'b1001; settle();
    chk("abandon_gnt", 32'(gnt), 32'h2);
    chk("abandon_valid", 32'(out_valid), 32'h0);
    tick(); settle();
    chk("abandon_next_gnt", 32'(gnt), 32'h8);
    chk("abandon_next_sel", 32'(sel), 32'h3);

    // Owner 3 finishes alone: the arbiter idles, then wraps to requester 0.
    req = 4'b1000; last = 4'b1000; out_ready = 1'b1; settle();
    chk("last3_valid", 32'(out_valid), 32'h1);
    tick();
    req = 4'b0001; last = 4'b0000; settle();
    chk("idle_gnt", 32'(gnt), 32'h0);
    chk("idle_busy", 32'(busy), 32'h0);
    chk("idle_sel_hold", 32'(sel), 32'h3);
    tick(); settle();
    chk("wrap_gnt", 32'(gnt), 32'h1);
    chk("wrap_sel", 32'(sel), 32'h0);

    // Owner 2 stalls with last high; it releases only once out_ready returns.
    req = 4'b0100; settle();
    chk("to2_valid", 32'(out_valid), 32'h0);
    tick();
    out_ready = 1'b0; last = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      settle();
`ifndef GRANT_TIMEOUT_EN
      chk($sformatf("stall_gnt_%0d", i), 32'(gnt), 32'h4);
      chk($sformatf("stall_valid_%0d", i), 32'(out_valid), 32'h1);
`endif
      tick();
    end
    out_ready = 1'b1; settle();
`ifndef GRANT_TIMEOUT_EN
    chk("stall_rel_gnt", 32'(gnt), 32'h4);
`endif
    tick(); settle();
`ifndef GRANT_TIMEOUT_EN
    chk("stall_after_gnt", 32'(gnt), 32'h0);
`endif

    // Owner 0 never sends last.
    rst = 1'b1; req = 4'b0011; last = 4'b0000; out_ready = 1'b1;
    tick(); settle();
    chk("rst2_gnt", 32'(gnt), 32'h0);
    rst = 1'b0;
    tick();
`ifdef GRANT_TIMEOUT_EN
    for (int c = 1; c <= 4; c++) begin
      settle();
      chk($sformatf("hold_gnt_c%0d", c), 32'(gnt), 32'h1);
      chk($sformatf("hold_tmo_c%0d", c), 32'(timeout), 32'(c == 4));
      tick();
    end
    settle();
    chk("tmo_next_gnt", 32'(gnt), 32'h2);
    chk("tmo_next_tmo", 32'(timeout), 32'h0);
`else
    for (int c = 1; c <= 8; c++) begin
      settle();
      chk($sformatf("hold_gnt_c%0d", c), 32'(gnt), 32'h1);
      chk($sformatf("hold_tmo_c%0d", c), 32'(timeout), 32'h0);
      tick();
    end
`endif

    req = 4'b0000;
    tick(); tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
